// File: rtl/feature_packer.sv
// Collects NUM_FEATURES signed words into one wide vector and flags frames whose length is wrong.
// m_valid rises 1 cycle after the last beat; s_ready drops while the vector is held for downstream.
module feature_packer #(
  parameter int NUM_FEATURES  = 300,
  parameter int DATA_WIDTH    = 32,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               s_valid,
  output logic                               s_ready,
  input  logic [DATA_WIDTH-1:0]              s_data,
  input  logic                               s_last,
  output logic                               m_valid,
  input  logic                               m_ready,
  output logic [NUM_FEATURES*DATA_WIDTH-1:0] m_features,
  output logic                               o_frame_err,
  output logic [ERR_CNT_WIDTH-1:0]           o_err_count
);

  localparam int IDX_W = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FEATURES - 1);

  typedef enum logic [1:0] {FILL, HOLD, DROP} state_t;

  state_t                   state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic                     live_q;
  logic                     err_q, err_d;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
  logic [DATA_WIDTH-1:0]    feat_q [NUM_FEATURES];
  logic                     s_fire;
  logic                     m_fire;
  logic                     wr_en;

  // live_q keeps s_ready low while in reset and raises it on the first edge after release
  assign s_ready = live_q && (state_q != HOLD);
  assign m_valid = (state_q == HOLD);
  assign s_fire  = s_valid && s_ready;
  assign m_fire  = m_valid && m_ready;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    err_d   = 1'b0;
    wr_en   = 1'b0;
    case (state_q)
      FILL: begin
        if (s_fire) begin
          wr_en = 1'b1;
          if (idx_q == LAST_IDX) begin
            idx_d = '0;
            if (s_last) begin
              state_d = HOLD;
            end else begin
              state_d = DROP;
              err_d   = 1'b1;
            end
          end else if (s_last) begin
            idx_d = '0;
            err_d = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      HOLD: begin
        if (m_fire) state_d = FILL;
      end
      DROP: begin
        if (s_fire && s_last) state_d = FILL;
      end
      default: state_d = FILL;
    endcase
    err_cnt_d = (err_d && (err_cnt_q != '1)) ? err_cnt_q + ERR_CNT_WIDTH'(1) : err_cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= FILL;
      idx_q     <= '0;
      live_q    <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      live_q    <= 1'b1;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_FEATURES; k++) feat_q[k] <= '0;
    end else if (wr_en) begin
      feat_q[idx_q] <= s_data;
    end
  end

  for (genvar k = 0; k < NUM_FEATURES; k++) begin : g_pack
    assign m_features[k*DATA_WIDTH +: DATA_WIDTH] = feat_q[k];
  end

  assign o_frame_err = err_q;
  assign o_err_count = err_cnt_q;

endmodule

// File: tb/tb_feature_packer.sv
// Directed bench for feature_packer: good, held, short, long and reset-interrupted frames,
// plus saturation of the malformed-frame counter.
module tb_feature_packer;

  localparam int NF = 300;
  localparam int DW = 32;
  localparam int EW = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             s_valid;
  logic             s_ready;
  logic [DW-1:0]    s_data;
  logic             s_last;
  logic             m_valid;
  logic             m_ready;
  logic [NF*DW-1:0] m_features;
  logic             o_frame_err;
  logic [EW-1:0]    o_err_count;

  feature_packer #(.NUM_FEATURES(NF), .DATA_WIDTH(DW), .ERR_CNT_WIDTH(EW)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_features(m_features),
    .o_frame_err(o_frame_err), .o_err_count(o_err_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int xfer_cnt = 0;
  int err_pulses = 0;
  logic [NF*DW-1:0] xfer_vec = '0;
  logic [DW-1:0] exp_w [NF];
  logic [NF*DW-1:0] snap;
  int exp_errs;
  int x0, e0;

  always @(posedge clk) begin
    if (m_valid && m_ready) begin
      xfer_cnt++;
      xfer_vec = m_features;
    end
    if (o_frame_err) err_pulses++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after the beat was accepted.
  task automatic send_beat(input logic [DW-1:0] d, input logic last);
    int n = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    while (!s_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("s_ready_wait", {31'b0, s_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_seq(input int n, input int last_idx, input logic [DW-1:0] base,
                          input logic [DW-1:0] mul, input bit rec);
    for (int k = 0; k < n; k++) begin
      logic [DW-1:0] d;
      d = base + DW'(k) * mul;
      if (rec && k < NF) exp_w[k] = d;
      send_beat(d, k == last_idx);
    end
  endtask

  task automatic check_xfer(input string tag);
    for (int k = 0; k < NF; k++) chk(tag, xfer_vec[k*DW +: DW], exp_w[k]);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b1;
    exp_errs = 0;
    repeat (3) @(negedge clk);
    chk("rst_s_ready", {31'b0, s_ready}, 32'd0);
    chk("rst_m_valid", {31'b0, m_valid}, 32'd0);
    chk("rst_frame_err", {31'b0, o_frame_err}, 32'd0);
    chk("rst_err_count", {16'b0, o_err_count}, 32'd0);
    chk("rst_features", {31'b0, |m_features}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("s_ready_after_rst", {31'b0, s_ready}, 32'd1);

    // Good frame, word k = k<<16, downstream always ready
    x0 = xfer_cnt;
    send_seq(NF, NF-1, 32'h0, 32'h10000, 1'b1);
    idle();
    chk("a_m_valid_hi", {31'b0, m_valid}, 32'd1);
    chk("a_s_ready_lo", {31'b0, s_ready}, 32'd0);
    @(negedge clk);
    chk("a_m_valid_lo", {31'b0, m_valid}, 32'd0);
    chk("a_s_ready_hi", {31'b0, s_ready}, 32'd1);
    chk("a_xfers", 32'(xfer_cnt - x0), 32'd1);
    check_xfer("a_word");

    // Downstream stalls 20 cycles; negative words stored unmodified
    m_ready = 1'b0;
    x0 = xfer_cnt;
    send_seq(NF, NF-1, 32'hF000_0000, 32'h1, 1'b1);
    idle();
    snap = m_features;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("b_s_ready_lo", {31'b0, s_ready}, 32'd0);
      chk("b_m_valid_hi", {31'b0, m_valid}, 32'd1);
      chk("b_stable", {31'b0, m_features === snap}, 32'd1);
    end
    chk("b_no_xfer", 32'(xfer_cnt - x0), 32'd0);
    m_ready = 1'b1;
    @(negedge clk);
    chk("b_xfers", 32'(xfer_cnt - x0), 32'd1);
    chk("b_m_valid_lo", {31'b0, m_valid}, 32'd0);
    check_xfer("b_word");

    // Short frame: 150 beats
    x0 = xfer_cnt; e0 = err_pulses;
    send_seq(150, 149, 32'h0BAD_0000, 32'h1, 1'b0);
    idle();
    chk("c_err_pulse", {31'b0, o_frame_err}, 32'd1);
    exp_errs++;
    @(negedge clk);
    chk("c_err_pulse_end", {31'b0, o_frame_err}, 32'd0);
    chk("c_err_count", {16'b0, o_err_count}, 32'(exp_errs));
    chk("c_pulses", 32'(err_pulses - e0), 32'd1);
    chk("c_m_valid_lo", {31'b0, m_valid}, 32'd0);
    send_seq(NF, NF-1, 32'h0000_1000, 32'h1, 1'b1);
    idle();
    @(negedge clk);
    chk("c_xfers", 32'(xfer_cnt - x0), 32'd1);
    check_xfer("c_word");

    // Long frame: 305 beats, last on beat 304
    x0 = xfer_cnt; e0 = err_pulses;
    send_seq(NF, -1, 32'h0123_0000, 32'h1, 1'b1);
    chk("d_err_pulse", {31'b0, o_frame_err}, 32'd1);
    exp_errs++;
    send_seq(5, 4, 32'hDEAD_0000, 32'h1, 1'b0);
    idle();
    @(negedge clk);
    chk("d_err_count", {16'b0, o_err_count}, 32'(exp_errs));
    chk("d_pulses", 32'(err_pulses - e0), 32'd1);
    chk("d_no_xfer", 32'(xfer_cnt - x0), 32'd0);
    for (int k = 0; k < 5; k++) chk("d_dropped", m_features[k*DW +: DW], exp_w[k]);
    send_seq(NF, NF-1, 32'h4000_0000, 32'h3, 1'b1);
    idle();
    @(negedge clk);
    chk("d_xfers", 32'(xfer_cnt - x0), 32'd1);
    check_xfer("d_word");

    // Reset after beat 100 discards the partial frame
    send_seq(101, -1, 32'h5555_0000, 32'h1, 1'b0);
    idle();
    rst = 1'b1;
    @(negedge clk);
    chk("e_rst_word0", m_features[31:0], 32'd0);
    chk("e_rst_word100", m_features[100*DW +: DW], 32'd0);
    chk("e_rst_err_count", {16'b0, o_err_count}, 32'd0);
    exp_errs = 0;
    rst = 1'b0;
    @(negedge clk);
    chk("e_s_ready_hi", {31'b0, s_ready}, 32'd1);
    x0 = xfer_cnt;
    send_seq(NF, NF-1, 32'h7700_0000, 32'h1, 1'b1);
    idle();
    repeat (3) @(negedge clk);
    chk("e_xfers", 32'(xfer_cnt - x0), 32'd1);
    chk("e_word0", xfer_vec[31:0], 32'h7700_0000);
    check_xfer("e_word");

    // Counter saturation: 65534 one-beat short frames, then 3 more
    s_valid = 1'b1; s_last = 1'b1; s_data = 32'h1;
    repeat (65534) @(negedge clk);
    idle();
    @(negedge clk);
    chk("f_count_fffe", {16'b0, o_err_count}, 32'h0000_FFFE);
    for (int i = 0; i < 3; i++) begin
      send_beat(DW'(i), 1'b1);
      idle();
      chk("f_err_pulse", {31'b0, o_frame_err}, 32'd1);
      @(negedge clk);
      chk("f_count_sat", {16'b0, o_err_count}, 32'h0000_FFFF);
    end
    chk("f_s_ready", {31'b0, s_ready}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/feature_packer.md
FEATURE_PACKER -- requirements
Module: feature_packer

Interface
REQ-001 Parameter NUM_FEATURES, default 300: number of 32-bit feature words per frame.
REQ-002 Parameter DATA_WIDTH, default 32: width of one feature word, signed Q16.16.
REQ-003 Parameter ERR_CNT_WIDTH, default 16: width of the frame-error counter.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 s_valid  input  1  upstream word valid.
REQ-007 s_ready  output  1  block accepts a word this cycle.
REQ-008 s_data  input  DATA_WIDTH  one feature word, signed.
REQ-009 s_last  input  1  marks final word of a frame.
REQ-010 m_valid  output  1  packed vector valid, drives the first dense layer's i_valid.
REQ-011 m_ready  input  1  downstream ready, driven by the first dense layer's i_ready.
REQ-012 m_features  output  NUM_FEATURES*DATA_WIDTH  packed vector, word k at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-013 o_frame_err  output  1  one-cycle pulse on a malformed frame.
REQ-014 o_err_count  output  ERR_CNT_WIDTH  saturating count of malformed frames.

Function
REQ-015 A beat SHALL be accepted when s_valid and s_ready are both high on a rising edge; m-side transfer SHALL occur when m_valid and m_ready are both high.
REQ-016 The FSM SHALL have exactly three states: FILL, HOLD, DROP.
REQ-017 In FILL, s_ready SHALL be 1 and m_valid SHALL be 0; each accepted beat SHALL write s_data into slot idx and increment idx (idx range 0..NUM_FEATURES-1).
REQ-018 FILL: accepted beat with idx==NUM_FEATURES-1 and s_last=1 SHALL write the slot, clear idx, and move to HOLD; m_valid SHALL go high the following cycle (latency 1 cycle after the last beat).
REQ-019 FILL: accepted beat with idx<NUM_FEATURES-1 and s_last=1 (short frame) SHALL pulse o_frame_err the next cycle, clear idx, stay in FILL, and leave m_valid low.
REQ-020 FILL: accepted beat with idx==NUM_FEATURES-1 and s_last=0 (long frame) SHALL pulse o_frame_err the next cycle, clear idx, and move to DROP.
REQ-021 In DROP, s_ready SHALL be 1, beats SHALL be discarded without writing m_features, and an accepted beat with s_last=1 SHALL return the FSM to FILL with idx=0.
REQ-022 In HOLD, s_ready SHALL be 0, m_valid SHALL be 1, and m_features SHALL remain bit-stable until transfer.
REQ-023 HOLD: on transfer, the FSM SHALL return to FILL; m_valid SHALL be 0 and s_ready 1 on the next cycle.
REQ-024 Minimum frame period SHALL be NUM_FEATURES+1 cycles when m_ready is held high.
REQ-025 Slots not rewritten SHALL retain prior values; m_features SHALL only be sampled by downstream in HOLD.
REQ-026 Each malformed frame SHALL increment o_err_count by 1, saturating at all-ones with no wrap.
REQ-027 s_ready and m_valid SHALL be decoded from registered state only, with no combinational path from m_ready or s_valid.
REQ-028 s_data SHALL be stored unmodified, with no sign or width conversion.

Reset
REQ-029 While rst is high: state=FILL, idx=0, m_valid=0, s_ready=0, m_features=0, o_frame_err=0, o_err_count=0.
REQ-030 Reset asserted mid-frame or in HOLD SHALL discard the partial or held vector; the first beat after release SHALL be written to slot 0.
REQ-031 s_ready SHALL go high the first clock edge after rst deasserts.

Verification
REQ-032 Send 300 beats with s_data=k<<16 for k=0..299, s_last on beat 299, m_ready=1 -> m_valid high 1 cycle after the last beat; word k = k<<16; m_valid low the next cycle.
REQ-033 Send a full frame with m_ready=0 for 20 cycles -> s_ready=0 and m_features stable for all 20 cycles; one transfer when m_ready rises.
REQ-034 Send 150 beats with s_last on beat 149 -> o_frame_err pulses once; o_err_count=1; m_valid stays low; the next 300-beat frame packs correctly from slot 0.
REQ-035 Send 305 beats with s_last on beat 304 -> o_frame_err pulses after beat 299; beats 300-304 are dropped; o_err_count=1; a following good frame is correct.
REQ-036 Assert rst after beat 100, then send a full frame -> word 0 equals the first post-reset beat, and exactly one m_valid frame is produced.
REQ-037 Force o_err_count to all-ones minus 1 and inject 3 short frames -> counter saturates at 0xFFFF with no wrap.
